// File: rtl/bus_arbiter_split.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_split
//  Purpose  : Two-master bus arbiter with split/retry handling, locked
//             tenures, round-robin tie breaking and tenure-based preemption.
//             All outputs are registered.
//  Ports    : CLK        - system clock, rising edge
//             RST        - synchronous active-high reset
//             HBUSREQ    - bus request (bit0 master 1, bit1 master 2)
//             HLOCK      - locked-transfer request per master
//             HREADY     - current transfer completes this cycle
//             HRESP      - slave response (00 OKAY 01 ERROR 10 RETRY 11 SPLIT)
//             HSPLIT     - split release, bit i re-enables master i+1
//             HGRANT     - one-hot grant, 00 when no owner
//             HMAS       - owner ID to the slaves (00 none, 01 m1, 10 m2)
//             MLOCK      - owner holds a locked tenure
//             SPLIT_PEND - split mask, bit i set while master i+1 is parked
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_split #(
   parameter int TENURE = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] HBUSREQ,
   input  logic [1:0] HLOCK,
   input  logic       HREADY,
   input  logic [1:0] HRESP,
   input  logic [1:0] HSPLIT,
   output logic [1:0] HGRANT,
   output logic [1:0] HMAS,
   output logic       MLOCK,
   output logic [1:0] SPLIT_PEND
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam int            CW      = (TENURE > 1) ? $clog2(TENURE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TENURE - 1);

   localparam logic [1:0] RESP_RETRY = 2'b10;
   localparam logic [1:0] RESP_SPLIT = 2'b11;

   logic [0:0]    state;
   logic          owner;        // 0 = master 1, 1 = master 2
   logic          last_owner;
   logic [CW-1:0] tenure_cnt;

   logic [1:0] eligible;
   logic       winner;
   logic       own_req;
   logic       own_lock;
   logic       other_elig;
   logic       do_split;
   logic       do_retry;
   logic       do_drop;
   logic       do_preempt;
   logic       release_bus;
   logic [1:0] split_set;
   logic [1:0] owner_onehot;
   logic [1:0] winner_onehot;

   // Parked masters are invisible to arbitration.
   assign eligible = HBUSREQ & ~SPLIT_PEND;

   // Round-robin: on a tie the master that did not own last wins.
   always_comb begin
      winner = 1'b0;
      if (eligible == 2'b11) begin
         winner = ~last_owner;
      end else if (eligible[0]) begin
         winner = 1'b0;
      end else begin
         winner = 1'b1;
      end
   end

   assign winner_onehot = winner ? 2'b10 : 2'b01;
   assign owner_onehot  = owner  ? 2'b10 : 2'b01;

   assign own_req    = HBUSREQ[owner];
   assign own_lock   = HLOCK[owner];
   assign other_elig = eligible[~owner];

   assign do_split   = (HRESP == RESP_SPLIT);
   assign do_retry   = (HRESP == RESP_RETRY);
   assign do_drop    = !own_req && !own_lock;
   // Uses the lock registered for the tenure so far, so a lock cannot be
   // dodged by the preempt check on the same cycle.
   assign do_preempt = (tenure_cnt == CNT_MAX) && !MLOCK && other_elig;

   // Release conditions only matter on completed transfers. ERROR falls
   // through to the drop/preempt checks like OKAY.
   assign release_bus = (state == BUSY) && HREADY &&
                        (do_split || do_retry || do_drop || do_preempt);

   assign split_set = ((state == BUSY) && HREADY && do_split) ? owner_onehot : 2'b00;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         tenure_cnt <= '0;
         HGRANT     <= 2'b00;
         HMAS       <= 2'b00;
         MLOCK      <= 1'b0;
         SPLIT_PEND <= 2'b00;
      end else begin
         // A release on the same edge beats a new split for that master.
         SPLIT_PEND <= (SPLIT_PEND | split_set) & ~HSPLIT;

         case (state)
            IDLE: begin
               if (|eligible) begin
                  state      <= BUSY;
                  owner      <= winner;
                  last_owner <= winner;
                  tenure_cnt <= '0;
                  MLOCK      <= HLOCK[winner];
                  HGRANT     <= winner_onehot;
                  HMAS       <= winner_onehot;
               end
            end
            BUSY: begin
               if (HREADY) begin
                  if (release_bus) begin
                     // Going back through IDLE guarantees one dead cycle
                     // with HMAS=00 before the next grant.
                     state  <= IDLE;
                     MLOCK  <= 1'b0;
                     HGRANT <= 2'b00;
                     HMAS   <= 2'b00;
                  end else begin
                     MLOCK <= own_lock;
                     if (tenure_cnt != CNT_MAX) begin
                        tenure_cnt <= tenure_cnt + CW'(1);
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_split.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter_split
//  Purpose  : Self-checking bench for bus_arbiter_split (TENURE=4). Stimulus
//             drives inputs on the falling edge and pushes the expected
//             registered outputs of the following rising edge into a queue;
//             a monitor pops and compares one entry per rising edge.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_split;

   localparam int TENURE = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [1:0] HBUSREQ = 2'b00;
   logic [1:0] HLOCK = 2'b00;
   logic       HREADY = 1'b1;
   logic [1:0] HRESP = 2'b00;
   logic [1:0] HSPLIT = 2'b00;
   logic [1:0] HGRANT;
   logic [1:0] HMAS;
   logic       MLOCK;
   logic [1:0] SPLIT_PEND;

   bus_arbiter_split #(.TENURE(TENURE)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .HBUSREQ    (HBUSREQ),
      .HLOCK      (HLOCK),
      .HREADY     (HREADY),
      .HRESP      (HRESP),
      .HSPLIT     (HSPLIT),
      .HGRANT     (HGRANT),
      .HMAS       (HMAS),
      .MLOCK      (MLOCK),
      .SPLIT_PEND (SPLIT_PEND)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0] hgrant;
      logic [1:0] hmas;
      logic       mlock;
      logic [1:0] split_pend;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: owner as a master number (0 = none), parked flags
   // indexed by master number, tenure as a plain count of completed transfers.
   int m_owner = 0;
   int m_last  = 2;
   int m_count = 0;
   bit m_lock  = 1'b0;
   bit m_mask [1:2];

   task automatic model_step(input logic rst, input logic [1:0] req, input logic [1:0] lk,
                             input logic rdy, input logic [1:0] resp, input logic [1:0] spl);
      bit elig [1:2];
      int win;
      int oth;
      bit rel;
      if (rst) begin
         m_owner   = 0;
         m_last    = 2;
         m_count   = 0;
         m_lock    = 1'b0;
         m_mask[1] = 1'b0;
         m_mask[2] = 1'b0;
         return;
      end
      elig[1] = req[0] && !m_mask[1];
      elig[2] = req[1] && !m_mask[2];
      if (m_owner == 0) begin
         win = 0;
         if (elig[1] && elig[2]) win = (m_last == 1) ? 2 : 1;
         else if (elig[1])       win = 1;
         else if (elig[2])       win = 2;
         if (win != 0) begin
            m_owner = win;
            m_last  = win;
            m_lock  = lk[win-1];
            m_count = 0;
         end
      end else if (rdy) begin
         oth = 3 - m_owner;
         rel = 1'b0;
         if (resp == 2'b11) begin
            rel = 1'b1;
            m_mask[m_owner] = 1'b1;
         end else if (resp == 2'b10) begin
            rel = 1'b1;
         end else if (!req[m_owner-1] && !lk[m_owner-1]) begin
            rel = 1'b1;
         end else if (m_count == TENURE - 1 && !m_lock && elig[oth]) begin
            rel = 1'b1;
         end
         if (rel) begin
            m_owner = 0;
            m_lock  = 1'b0;
         end else begin
            m_lock = lk[m_owner-1];
            if (m_count < TENURE - 1) m_count = m_count + 1;
         end
      end
      if (spl[0]) m_mask[1] = 1'b0;
      if (spl[1]) m_mask[2] = 1'b0;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.hgrant     = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      e.hmas       = e.hgrant;
      e.mlock      = m_lock;
      e.split_pend = {m_mask[2], m_mask[1]};
      return e;
   endfunction

   // Drive one cycle of inputs and record what the next rising edge must yield.
   task automatic cycle(input logic rst, input logic [1:0] req, input logic [1:0] lk,
                        input logic rdy, input logic [1:0] resp, input logic [1:0] spl);
      @(negedge CLK);
      RST     = rst;
      HBUSREQ = req;
      HLOCK   = lk;
      HREADY  = rdy;
      HRESP   = resp;
      HSPLIT  = spl;
      model_step(rst, req, lk, rdy, resp, spl);
      exp_q.push_back(model_out());
   endtask

   task automatic compare(input string name, input exp_t got, input exp_t req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s @%0t: got hgrant=%b hmas=%b mlock=%b split_pend=%b, required hgrant=%b hmas=%b mlock=%b split_pend=%b",
                  name, $time, got.hgrant, got.hmas, got.mlock, got.split_pend,
                  req.hgrant, req.hmas, req.mlock, req.split_pend);
      end
   endtask

   // Directed check of hand-derived constants right after the coming edge.
   task automatic expect_now(input string name, input logic [1:0] hg, input logic [1:0] hm,
                             input logic ml, input logic [1:0] sp);
      exp_t req;
      exp_t got;
      @(posedge CLK);
      #2;
      req = {hg, hm, ml, sp};
      got = {HGRANT, HMAS, MLOCK, SPLIT_PEND};
      compare(name, got, req);
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {HGRANT, HMAS, MLOCK, SPLIT_PEND};
            compare("scoreboard", got, e);
         end
      end
   end

   initial begin
      logic [1:0] req;
      logic [1:0] lk;
      logic       rdy;
      logic [1:0] resp;
      logic [1:0] spl;
      logic       rst;
      int         r;
      m_mask[1] = 1'b0;
      m_mask[2] = 1'b0;

      // Reset state.
      cycle(1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("reset", 2'b00, 2'b00, 1'b0, 2'b00);

      // Tie after reset goes to master 1, then master 2 after a dead cycle.
      cycle(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("tie_m1", 2'b01, 2'b01, 1'b0, 2'b00);
      cycle(1'b0, 2'b10, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("drop_idle", 2'b00, 2'b00, 1'b0, 2'b00);
      cycle(1'b0, 2'b10, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("grant_m2", 2'b10, 2'b10, 1'b0, 2'b00);
      cycle(1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00);

      // Split: master 1 parked, request ignored, released by HSPLIT.
      cycle(1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("split_grant", 2'b01, 2'b01, 1'b0, 2'b00);
      cycle(1'b0, 2'b01, 2'b00, 1'b1, 2'b11, 2'b00);
      expect_now("split_park", 2'b00, 2'b00, 1'b0, 2'b01);
      cycle(1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("split_ignored", 2'b00, 2'b00, 1'b0, 2'b01);
      cycle(1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 2'b01);
      expect_now("split_release", 2'b00, 2'b00, 1'b0, 2'b00);
      cycle(1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("split_regrant", 2'b01, 2'b01, 1'b0, 2'b00);
      cycle(1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00);

      // Tenure preemption after TENURE completed transfers.
      cycle(1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00);
      cycle(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("tenure_grant", 2'b01, 2'b01, 1'b0, 2'b00);
      for (int i = 0; i < TENURE - 1; i++) begin
         cycle(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00);
         expect_now("tenure_hold", 2'b01, 2'b01, 1'b0, 2'b00);
      end
      cycle(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("tenure_preempt", 2'b00, 2'b00, 1'b0, 2'b00);
      cycle(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("tenure_m2", 2'b10, 2'b10, 1'b0, 2'b00);

      // Lock holds the bus past the tenure; a SPLIT still breaks it.
      cycle(1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("lock_pre_idle", 2'b00, 2'b00, 1'b0, 2'b00);
      cycle(1'b0, 2'b11, 2'b01, 1'b1, 2'b00, 2'b00);
      expect_now("lock_grant", 2'b01, 2'b01, 1'b1, 2'b00);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 2'b11, 2'b01, 1'b1, 2'b00, 2'b00);
         expect_now("lock_hold", 2'b01, 2'b01, 1'b1, 2'b00);
      end
      cycle(1'b0, 2'b11, 2'b01, 1'b1, 2'b11, 2'b00);
      expect_now("lock_split", 2'b00, 2'b00, 1'b0, 2'b01);
      cycle(1'b0, 2'b11, 2'b01, 1'b1, 2'b00, 2'b00);
      expect_now("lock_m2", 2'b10, 2'b10, 1'b0, 2'b01);

      // Reset mid-tenure with a parked master.
      cycle(1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("reset_mid", 2'b00, 2'b00, 1'b0, 2'b00);
      cycle(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00);
      expect_now("reset_tie", 2'b01, 2'b01, 1'b0, 2'b00);

      // Same-edge split set and release.
      cycle(1'b0, 2'b11, 2'b00, 1'b1, 2'b11, 2'b01);
      expect_now("split_and_release", 2'b00, 2'b00, 1'b0, 2'b00);
      cycle(1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 249) == 0);
         req  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) req = 2'b11;
         lk   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         rdy  = ($urandom_range(0, 3) != 0);
         r    = $urandom_range(0, 19);
         resp = (r < 15) ? 2'b00 : (r < 17) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
         spl  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         cycle(rst, req, lk, rdy, resp, spl);
      end

      // Bounded drain of the scoreboard.
      repeat (4) @(posedge CLK);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_split.md
BUS_ARBITER_SPLIT -- requirements
Module: bus_arbiter_split

Interface
REQ-001 SHALL have parameter TENURE, default 16, meaning the maximum number of completed transfers (HREADY=1 cycles) an unlocked owner keeps the bus while the other master waits.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port HBUSREQ  input  2  bus request; bit0 = master 1, bit1 = master 2.
REQ-005 SHALL have port HLOCK  input  2  locked-transfer request per master (same bit order).
REQ-006 SHALL have port HREADY  input  1  current transfer completes this cycle (from the selected slave).
REQ-007 SHALL have port HRESP  input  2  slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
REQ-008 SHALL have port HSPLIT  input  2  split release from the slave; bit i=1 re-enables master i+1.
REQ-009 SHALL have port HGRANT  output  2  one-hot grant to the owning master, 00 when there is no owner.
REQ-010 SHALL have port HMAS  output  2  owner ID to the slaves: 00 none, 01 master 1, 10 master 2.
REQ-011 SHALL have port MLOCK  output  1  current owner holds a locked tenure.
REQ-012 SHALL have port SPLIT_PEND  output  2  split mask; bit i=1 means master i+1 is parked.

Function
REQ-013 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-014 SHALL implement states IDLE (no owner; HGRANT=00, HMAS=00, MLOCK=0) and BUSY (one owner).
REQ-015 SHALL treat a master as eligible when its HBUSREQ=1 and its SPLIT_PEND bit is 0.
REQ-016 SHALL, in IDLE, on an edge with at least one eligible master, enter BUSY and assert HGRANT/HMAS for the winner after that edge (1-cycle grant latency).
REQ-017 SHALL resolve two eligible masters round-robin: the master that is not the last owner wins; after reset the last owner is master 2, so master 1 wins the first tie.
REQ-018 SHALL, on entering BUSY, load MLOCK with the winner's HLOCK bit, and clear the tenure counter.
REQ-019 SHALL, while in BUSY, update MLOCK to the owner's HLOCK on every cycle with HREADY=1.
REQ-020 SHALL evaluate release conditions in BUSY only on cycles with HREADY=1, with priority SPLIT > RETRY > drop > preempt.
REQ-021 SHALL, on HRESP=11 (SPLIT), set the owner's SPLIT_PEND bit, clear MLOCK, and return to IDLE; SPLIT overrides a lock.
REQ-022 SHALL, on HRESP=10 (RETRY), return to IDLE without masking the owner.
REQ-023 SHALL, when the owner's HBUSREQ=0 and HLOCK=0, return to IDLE.
REQ-024 SHALL increment the tenure counter on each HREADY=1 cycle, saturating at TENURE-1.
REQ-025 SHALL preempt when the counter equals TENURE-1, MLOCK=0, and the other master is eligible, returning to IDLE.
REQ-026 SHALL never preempt while MLOCK=1.
REQ-027 SHALL treat HRESP=01 (ERROR) as no arbitration event.
REQ-028 SHALL hold every release for one full IDLE cycle (HMAS=00) before the next grant.
REQ-029 SHALL clear SPLIT_PEND[i] on any edge where HSPLIT[i]=1.
REQ-030 SHALL give HSPLIT[i] priority over a simultaneous SPLIT set for the same master, so the bit ends at 0.
REQ-031 SHALL ignore HBUSREQ from masked masters; if both masters are masked it SHALL remain in IDLE indefinitely.
REQ-032 SHALL ignore HSPLIT bits for unmasked masters.

Reset
REQ-033 SHALL, on any edge with RST=1, including mid-tenure, force IDLE, HGRANT=00, HMAS=00, MLOCK=0, SPLIT_PEND=00, tenure counter=0, last owner=master 2.

Verification
REQ-034 SHALL cover a tie after reset: HBUSREQ=11 -> one edge later HGRANT=01, HMAS=01; drop master 1's request -> IDLE cycle, then HGRANT=10, HMAS=10.
REQ-035 SHALL cover a split: master 1 owns, HRESP=11 with HREADY=1 -> HMAS=00, SPLIT_PEND=01; master 1 request ignored; HSPLIT=01 for one cycle -> SPLIT_PEND=00, then HMAS=01 on the following arbitration.
REQ-036 SHALL cover tenure preemption with TENURE=4 and both masters requesting, unlocked: master 1 granted, 4 HREADY cycles -> IDLE one cycle -> HMAS=10.
REQ-037 SHALL cover a lock: master 1 with HLOCK=01 and both requesting for 10 HREADY cycles -> MLOCK=1, HMAS stays 01 throughout; then a SPLIT response -> MLOCK=0, SPLIT_PEND=01.
REQ-038 SHALL cover reset mid-tenure: RST=1 for one edge while HMAS=10 and SPLIT_PEND=01 -> all outputs 0 after the edge; a subsequent tie grants master 1.
REQ-039 SHALL cover simultaneous split set and release: HRESP=11 and HSPLIT=01 on the same edge while master 1 owns -> SPLIT_PEND=00, state IDLE.
